// File: rtl/instr_fetch_queue.sv
// Prefetching fetch stage: issues ROM reads and buffers {instr, pc} pairs for decode via valid/ready.
// Optional FETCH_STATS_EN adds saturating flush_count / fetch_count outputs.
//
// state | meaning
// BOOT  | single idle cycle after reset, no ROM request
// FETCH | request while count + inflight < DEPTH and no redirect
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    rom_en,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [31:0]             rom_data,
    input  logic                    redirect,
    input  logic [31:0]             redirect_pc,
    output logic [31:0]             instr,
    output logic [31:0]             instr_pc,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [$clog2(DEPTH):0]  count
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]             flush_count,
    output logic [15:0]             fetch_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {BOOT, FETCH} state_t;

    state_t            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic [31:0]       inflight_pc_q, inflight_pc_d;
    logic [31:0]       data_q [DEPTH];
    logic [31:0]       data_d [DEPTH];
    logic [31:0]       pc_q [DEPTH];
    logic [31:0]       pc_d [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push;
    logic              pop;

    // Counting the in-flight response reserves its slot, so a push never finds the FIFO full.
    assign rom_en      = (state_q == FETCH) && !redirect &&
                         ((count_q + CNT_W'(inflight_q)) < CNT_W'(DEPTH));
    assign rom_addr    = fetch_pc_q[ADDR_W-1:0];
    assign instr_valid = (count_q != '0);
    assign push        = inflight_q && !redirect;
    assign pop         = instr_valid && instr_ready && !redirect;
    assign instr       = data_q[rptr_q];
    assign instr_pc    = pc_q[rptr_q];
    assign count       = count_q;

    always_comb begin
        state_d       = FETCH;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        data_d        = data_q;
        pc_d          = pc_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        count_d       = count_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc & ~32'h3;
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
        end else begin
            if (rom_en) begin
                fetch_pc_d    = fetch_pc_q + 32'd4;
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
            end
            if (push) begin
                data_d[wptr_q] = rom_data;
                pc_d[wptr_q]   = inflight_pc_q;
                wptr_d         = wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            data_q        <= data_d;
            pc_q          <= pc_d;
        end
    end

`ifdef FETCH_STATS_EN
    logic [15:0] flush_count_q, flush_count_d;
    logic [15:0] fetch_count_q, fetch_count_d;

    always_comb begin
        flush_count_d = flush_count_q;
        fetch_count_d = fetch_count_q;
        if (redirect && (flush_count_q != 16'hFFFF)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
        if (push && (fetch_count_q != 16'hFFFF)) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_count_q <= '0;
            fetch_count_q <= '0;
        end else begin
            flush_count_q <= flush_count_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign flush_count = flush_count_q;
    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: expected deliveries queued by the stimulus, popped by a monitor.
// Build with FETCH_STATS_EN defined to also exercise the statistics counters.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  count;
`ifdef FETCH_STATS_EN
    logic [15:0] flush_count;
    logic [15:0] fetch_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_pc_q [$];
    logic [31:0] mon_e;

    int t2_cnt [16] = '{0, 0, 0, 1, 2, 3, 4, 4, 4, 4, 4, 3, 2, 2, 2, 2};
    logic [7:0] t5_addr [3] = '{8'hFC, 8'h00, 8'h04};

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(4), .ADDR_W(8), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .count       (count)
`ifdef FETCH_STATS_EN
        ,
        .flush_count (flush_count),
        .fetch_count (fetch_count)
`endif
    );

    // ROM word i = 0x1000_0000 + i; garbage when not requested
    always @(posedge clk) begin
        if (rom_en) rom_data <= 32'h1000_0000 + {26'b0, rom_addr[7:2]};
        else        rom_data <= 32'hDEAD_DEAD;
    end

    function automatic logic [31:0] exp_data(input logic [31:0] pc);
        return 32'h1000_0000 + {26'b0, pc[7:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && redirect === 1'b0 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
            if (exp_pc_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got pc %h, none expected at %0t", instr_pc, $time);
            end else begin
                mon_e = exp_pc_q.pop_front();
                chk("pop_pc", instr_pc, mon_e);
                chk("pop_data", instr, exp_data(mon_e));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // single reset edge; returns at the start of the BOOT cycle
    task automatic do_reset();
        rst         = 1'b1;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        next_cycle();

        // streaming from reset
        for (int k = 0; k < 10; k++) exp_pc_q.push_back(32'(4 * k));
        do_reset();
        instr_ready = 1'b1;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("rst_rom_en", rom_en, 0);
                chk("rst_count", count, 0);
                chk("rst_instr", instr, 0);
                chk("rst_instr_pc", instr_pc, 0);
            end
            chk("t1_valid", instr_valid, (c >= 3));
            if (c >= 1) begin
                chk("t1_rom_en", rom_en, 1);
                chk("t1_rom_addr", rom_addr, 8'(4 * (c - 1)));
            end
            if (c <= 3) chk("t1_count", count, (c == 3) ? 1 : 0);
            next_cycle();
        end
        chk("t1_drained", exp_pc_q.size(), 0);

        // backpressure to full, then drain and refetch
        for (int k = 0; k < 6; k++) exp_pc_q.push_back(32'(4 * k));
        do_reset();
        for (int c = 0; c < 16; c++) begin
            if (c == 10) instr_ready = 1'b1;
            @(negedge clk);
            chk("t2_count", count, t2_cnt[c]);
            chk("t2_rom_en", rom_en, ((c >= 1 && c <= 4) || c >= 11));
            if (c >= 1 && c <= 4) chk("t2_rom_addr", rom_addr, 8'(4 * (c - 1)));
            if (c >= 11) chk("t2_refetch_addr", rom_addr, 8'(16 + 4 * (c - 11)));
            next_cycle();
        end
        instr_ready = 1'b0;
        chk("t2_drained", exp_pc_q.size(), 0);

        // redirect with 3 queued entries and a response in flight
        exp_pc_q.push_back(32'h40);
        exp_pc_q.push_back(32'h44);
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c == 5) begin
                redirect    = 1'b1;
                redirect_pc = 32'h0000_0042;
            end
            if (c == 6) begin
                redirect    = 1'b0;
                instr_ready = 1'b1;
            end
            @(negedge clk);
            if (c == 5) begin
                chk("t3_count_before", count, 3);
                chk("t3_rom_en_redir", rom_en, 0);
            end
            if (c == 6 || c == 7) begin
                chk("t3_count_flushed", count, 0);
                chk("t3_valid_flushed", instr_valid, 0);
                chk("t3_rom_en_after", rom_en, 1);
                chk("t3_rom_addr", rom_addr, (c == 6) ? 8'h40 : 8'h44);
            end
            if (c == 8) chk("t3_valid_new", instr_valid, 1);
            next_cycle();
        end
        instr_ready = 1'b0;
        chk("t3_drained", exp_pc_q.size(), 0);

        // redirect with a simultaneous pop, held 3 cycles
        exp_pc_q.push_back(32'h80);
        exp_pc_q.push_back(32'h84);
        exp_pc_q.push_back(32'h88);
        do_reset();
        instr_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            if (c == 3) begin
                redirect    = 1'b1;
                redirect_pc = 32'h0000_0080;
            end
            if (c == 6) redirect = 1'b0;
            @(negedge clk);
            if (c == 3) begin
                chk("t4_valid_at_redir", instr_valid, 1);
                chk("t4_rom_en_redir", rom_en, 0);
            end
            if (c == 4 || c == 5) begin
                chk("t4_count_held", count, 0);
                chk("t4_valid_held", instr_valid, 0);
                chk("t4_rom_en_held", rom_en, 0);
            end
            if (c == 6) begin
                chk("t4_count_resume", count, 0);
                chk("t4_rom_en_resume", rom_en, 1);
                chk("t4_rom_addr_resume", rom_addr, 8'h80);
            end
            if (c == 7) chk("t4_valid_latency", instr_valid, 0);
            if (c == 8) chk("t4_valid_new", instr_valid, 1);
            next_cycle();
        end
        instr_ready = 1'b0;
        chk("t4_drained", exp_pc_q.size(), 0);

        // PC wrap via redirect issued during BOOT (low bits forced to zero)
        exp_pc_q.push_back(32'hFFFF_FFFC);
        exp_pc_q.push_back(32'h0000_0000);
        exp_pc_q.push_back(32'h0000_0004);
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c == 0) begin
                redirect    = 1'b1;
                redirect_pc = 32'hFFFF_FFFE;
            end
            if (c == 1) begin
                redirect    = 1'b0;
                instr_ready = 1'b1;
            end
            @(negedge clk);
            if (c == 0) chk("t5_boot_rom_en", rom_en, 0);
            if (c >= 1 && c <= 3) begin
                chk("t5_rom_en", rom_en, 1);
                chk("t5_rom_addr", rom_addr, t5_addr[c - 1]);
            end
            if (c == 3) chk("t5_valid", instr_valid, 1);
            next_cycle();
        end
        instr_ready = 1'b0;
        chk("t5_drained", exp_pc_q.size(), 0);

`ifdef FETCH_STATS_EN
        // 5 redirects then 20 fetches
        for (int k = 0; k < 20; k++) exp_pc_q.push_back(32'h100 + 32'(4 * k));
        do_reset();
        for (int c = 0; c < 27; c++) begin
            if (c == 0) begin
                redirect    = 1'b1;
                redirect_pc = 32'h0000_0100;
            end
            if (c == 5) begin
                redirect    = 1'b0;
                instr_ready = 1'b1;
            end
            @(negedge clk);
            if (c == 5) chk("t6_flush_mid", flush_count, 5);
            if (c == 26) begin
                chk("t6_flush_count", flush_count, 5);
                chk("t6_fetch_count", fetch_count, 20);
            end
            next_cycle();
        end
        instr_ready = 1'b0;
        chk("t6_drained", exp_pc_q.size(), 0);
        do_reset();
        @(negedge clk);
        chk("t6_flush_rst", flush_count, 0);
        chk("t6_fetch_rst", fetch_count, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
